inst_fetch: RTL

Instruction fetch stage directly downstream of the PC sequencer. Owns the fetch PC and issues word reads on a valid/ready instruction-memory port. Buffers in-order responses in a small FIFO and presents {inst, pc, err} to decode over a valid/ready handshake. Handles redirects (taken branch/jal/jalr) by flushing buffered entries and discarding stale in-flight responses.

---
 rtl/inst_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word reads on the imem port,
// and buffers in-order responses for decode. Redirects flush the buffer and drop stale responses.
module inst_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h8000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        imem_rsp_err_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_err_o,
    output logic        busy_o
);
    localparam int FP_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TP_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_RUN, ST_MISAL, ST_HALT} state_t;

    function automatic logic [TP_W-1:0] tag_inc(input logic [TP_W-1:0] p);
        return (p == TP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t      state_q, state_nxt;
    logic [31:0] fetch_pc_q, fetch_pc_nxt;
    logic        req_valid_q, req_valid_nxt;
    logic [31:0] req_addr_q, req_addr_nxt;
    logic [CW-1:0] out_cnt_q, out_nxt;
    logic [CW-1:0] drop_q, drop_nxt;
    logic        stale_q, stale_nxt;
    logic [CW-1:0] fifo_cnt_q, cnt_nxt;
    logic [FP_W-1:0] fifo_rd_q, fifo_wr_q;
    logic [TP_W-1:0] tag_rd_q, tag_wr_q;

    logic [31:0] fifo_inst [FIFO_DEPTH];
    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic        fifo_err  [FIFO_DEPTH];
    logic [31:0] tag_pc    [MAX_OUTSTANDING];

    logic accept, pend_hold, fifo_nonempty, pop, drop_zero;
    logic rsp_keep, misal_push, push, fault, start;

    assign accept        = req_valid_q & imem_req_ready_i;
    assign pend_hold     = req_valid_q & ~imem_req_ready_i;
    assign fifo_nonempty = (fifo_cnt_q != '0);
    assign pop           = inst_valid_o & inst_ready_i;
    assign drop_zero     = (drop_q == '0);
    assign rsp_keep      = imem_rsp_valid_i & ~redirect_i & drop_zero;
    // The fault entry waits until every stale response (including a still-pending request) is gone.
    assign misal_push    = (state_q == ST_MISAL) & drop_zero & ~stale_q & ~redirect_i;
    assign push          = rsp_keep | misal_push;
    assign fault         = rsp_keep & imem_rsp_err_i;

    assign out_nxt = out_cnt_q + CW'(accept) - CW'(imem_rsp_valid_i);
    assign cnt_nxt = redirect_i ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);

    always_comb begin
        state_nxt = state_q;
        if (redirect_i) begin
            state_nxt = (redirect_pc_i[1:0] != 2'b00) ? ST_MISAL : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (fault) state_nxt = ST_HALT;
                ST_MISAL: if (misal_push) state_nxt = ST_HALT;
                default:  state_nxt = state_q;
            endcase
        end
    end

    always_comb begin
        drop_nxt  = drop_q;
        stale_nxt = stale_q;
        if (redirect_i || fault) begin
            // Everything still in flight after this edge belongs to the old stream.
            drop_nxt  = out_nxt;
            stale_nxt = pend_hold;
        end else begin
            drop_nxt  = drop_q - CW'(imem_rsp_valid_i & ~drop_zero) + CW'(accept & stale_q);
            stale_nxt = stale_q & ~accept;
        end

        fetch_pc_nxt = fetch_pc_q;
        if (redirect_i)
            fetch_pc_nxt = redirect_pc_i;
        else if (accept && !stale_q)
            fetch_pc_nxt = fetch_pc_q + 32'd4;

        // Credits cover accepted requests plus buffered entries, so a response never finds the FIFO full.
        start = (state_nxt == ST_RUN) && !pend_hold
             && (out_nxt < CW'(MAX_OUTSTANDING))
             && ((out_nxt + cnt_nxt) < CW'(FIFO_DEPTH));
        req_valid_nxt = pend_hold | start;
        req_addr_nxt  = start ? fetch_pc_nxt : req_addr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            out_cnt_q   <= '0;
            drop_q      <= '0;
            stale_q     <= 1'b0;
            fifo_cnt_q  <= '0;
            fifo_rd_q   <= '0;
            fifo_wr_q   <= '0;
            tag_rd_q    <= '0;
            tag_wr_q    <= '0;
        end else begin
            state_q     <= state_nxt;
            fetch_pc_q  <= fetch_pc_nxt;
            req_valid_q <= req_valid_nxt;
            req_addr_q  <= req_addr_nxt;
            out_cnt_q   <= out_nxt;
            drop_q      <= drop_nxt;
            stale_q     <= stale_nxt;
            fifo_cnt_q  <= cnt_nxt;
            if (redirect_i) begin
                fifo_rd_q <= '0;
                fifo_wr_q <= '0;
            end else begin
                fifo_rd_q <= fifo_rd_q + FP_W'(pop);
                fifo_wr_q <= fifo_wr_q + FP_W'(push);
            end
            if (accept)
                tag_wr_q <= tag_inc(tag_wr_q);
            if (imem_rsp_valid_i)
                tag_rd_q <= tag_inc(tag_rd_q);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            tag_pc[tag_wr_q] <= req_addr_q;
        if (push) begin
            fifo_inst[fifo_wr_q] <= rsp_keep ? imem_rsp_data_i : NOP;
            fifo_pc[fifo_wr_q]   <= rsp_keep ? tag_pc[tag_rd_q] : fetch_pc_q;
            fifo_err[fifo_wr_q]  <= rsp_keep ? imem_rsp_err_i : 1'b1;
        end
    end

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = req_addr_q;
    assign inst_valid_o     = fifo_nonempty & ~redirect_i;
    assign inst_o           = fifo_nonempty ? fifo_inst[fifo_rd_q] : '0;
    assign inst_pc_o        = fifo_nonempty ? fifo_pc[fifo_rd_q] : '0;
    assign inst_err_o       = fifo_nonempty & fifo_err[fifo_rd_q];
    assign busy_o           = (out_cnt_q != '0) | ~drop_zero | req_valid_q;

endmodule
